msg_sequencer: RTL
==================

# msg_sequencer

Parametrised message source feeding the packet processor. It holds a writable table of `DEPTH` messages of `MSG_W` bits and presents one message at a time on a valid/ready handshake. It advances on a conditioned push-button edge or on an optional auto-play timer, with selectable wrap-around or stop-at-end. It replaces the fixed 5-entry message ROM and raw button counter in the top level.

## Interface
- `MSG_W`, 168, message width in bits
- `DEPTH`, 8, table entries (≥2)
- `IDX_W`, `$clog2(DEPTH)`, index width
- `DEBOUNCE_CYC`, 16, stable cycles required before a button level is accepted
- `AUTO_W`, 24, auto-play period counter width

Ports:
- `clk`  in  1  system clock; all logic on posedge
- `rst`  in  1  reset, asynchronous assert, active-low
- `next_msg`  in  1  raw push button, asynchronous, active-high
- `restart`  in  1  synchronous pulse: return to entry 0, IDLE
- `wrap`  in  1  1 = wrap last→0; 0 = stop at last
- `len`  in  IDX_W+1  active entries; 0 or >DEPTH treated as DEPTH
- `auto_period`  in  AUTO_W  auto-advance interval in cycles; 0 = auto-play off
- `wr_en`  in  1  table write strobe
- `wr_addr`  in  IDX_W  table write address
- `wr_data`  in  MSG_W  table write data
- `msg`  out  MSG_W  presented message (registered)
- `msg_valid`  out  1  `msg` is valid
- `msg_ready`  in  1  consumer accepts when high with `msg_valid`
- `idx`  out  IDX_W  index of the presented or last-presented entry
- `last`  out  1  `idx` == len−1
- `done`  out  1  stopped at end (wrap=0)

## Operation
- Table: DEPTH×MSG_W registers, all cleared to 0 on reset; `wr_en` writes `wr_data` at `wr_addr` on the same edge.
- Advance event: one-cycle pulse from the button conditioner rising edge, or from the auto tick.
- States:
  - IDLE (reset): first advance → PRESENT at idx 0.
  - PRESENT: `msg_valid`=1; `msg` captured from the table on entry and held stable. On `msg_valid & msg_ready` → HOLD, or to the next entry if an advance is pending.
  - HOLD: advance → compute next index → PRESENT. At idx = len−1: wrap=1 → idx 0; wrap=0 → DONE.
  - DONE: `done`=1, `msg_valid`=0. Advances are ignored; only `restart` exits.
- Advance while in PRESENT sets a one-deep pending flag. Further advances while pending are discarded.
- `restart` has priority over everything. Next cycle: IDLE, idx 0, pending cleared, `msg_valid` 0, `done` 0.
- Auto timer:
  - Counts only in IDLE/HOLD while `auto_period`≠0.
  - Ticks when it reaches `auto_period`−1, then clears.
  - Also clears on any advance, on `restart`, and in PRESENT/DONE.
- A table write to the entry currently presented does not alter `msg`; it takes effect at the next presentation.
- `len` change mid-run: if idx ≥ new len, the next advance goes to 0 (wrap=1) or DONE (wrap=0).

## Timing
- Reset values: `msg`=0, `msg_valid`=0, `idx`=0, `last`=0, `done`=0, state IDLE, pending 0, timer 0.
- Button path: 2-FF synchroniser, then debounce, then rising-edge detect. Press to advance pulse is 2 + DEBOUNCE_CYC + 1 cycles.
- Advance pulse in HOLD/IDLE at edge N → `msg_valid`=1 with new `msg`/`idx` after edge N+1.
- Acceptance at edge N → `msg_valid`=0 after N. If pending, `msg_valid`=1 with next entry after N+1 (one bubble cycle).
- `last` and `done` are registered and update with `idx` and state.

## Configuration
- `MSG_SEQ_DEBOUNCE_EN` defined: debounce counter active. A level must be stable DEBOUNCE_CYC cycles before it is accepted.
- Not defined: no debounce counter. The edge is detected on the synchronised level, so press latency is 3 cycles. `DEBOUNCE_CYC` is ignored.

## Structure
- `msg_seq_pkg`: state enum (IDLE, PRESENT, HOLD, DONE), default `MSG_W`, and message field-width constants (header 24, four 32-bit fields, two 8-bit fields).
- Sub-module `btn_conditioner`: synchroniser, optional debounce, rising-edge pulse; parametrised by `DEBOUNCE_CYC`.

## Test plan
- Reset, write entries 0..3 with 0xA0..0xA3, len=4, wrap=1, ready=1, four presses → msgs 0xA0,0xA1,0xA2,0xA3. Fifth press → 0xA0, `last` low.
- wrap=0, len=3, ready=1, four presses → third shows idx 2 with `last`=1. Fourth → `done`=1, `msg_valid`=0. `restart` → IDLE, `done`=0, next press gives idx 0.
- ready=0 while PRESENT idx 1, three presses → `msg` stable at idx 1. Ready=1 → one bubble cycle, then idx 2 only (extra press dropped).
- auto_period=10, no presses → new presentation every 10 HOLD cycles plus handshake; auto_period=0 → no advance.
- Bounce: toggle `next_msg` every 3 cycles for 30 cycles, then hold high → exactly one advance with `MSG_SEQ_DEBOUNCE_EN`.
- Assert `rst` low mid-PRESENT → all outputs return to reset values immediately, table reads 0.

Source files
------------

// File: rtl/msg_seq_pkg.sv
// -----------------------------------------------------------------------------
// msg_seq_pkg
//   Shared types and constants for the message sequencer.
//   - state_t      : sequencer state (IDLE, PRESENT, HOLD, DONE)
//   - MSG_W_DEFAULT: default message width, the sum of the packet fields below
//   - field widths : 24-bit header, four 32-bit fields, two 8-bit tag fields
//   - field_lsb()  : bit position of the n-th 32-bit field inside a message
// -----------------------------------------------------------------------------
package msg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int HDR_W      = 24;
  localparam int FIELD_W    = 32;
  localparam int NUM_FIELDS = 4;
  localparam int TAG_W      = 8;
  localparam int NUM_TAGS   = 2;

  localparam int MSG_W_DEFAULT = HDR_W + NUM_FIELDS * FIELD_W + NUM_TAGS * TAG_W;

  // Header occupies the top bits; fields follow MSB-first, tags sit at the bottom.
  function automatic int field_lsb(input int n);
    return MSG_W_DEFAULT - HDR_W - (n + 1) * FIELD_W;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Turns a raw asynchronous push-button into a single-cycle advance pulse:
//   2-FF synchroniser -> optional debounce -> rising-edge detect (registered).
//   Optional debounce is enabled with the macro MSG_SEQ_DEBOUNCE_EN; without
//   it the edge is taken directly from the synchronised level (3-cycle latency)
//   and DEBOUNCE_CYC has no effect. With it, latency is 3 + DEBOUNCE_CYC.
//
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   btn   in  raw button level (asynchronous, active-high)
//   pulse out one-cycle pulse per accepted rising edge
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic level;
  logic level_d_reg;
  logic pulse_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef MSG_SEQ_DEBOUNCE_EN
  // The counter runs only while the synchronised input differs from the
  // accepted level; any return to the accepted level restarts the count.
  localparam int CNT_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);

  logic [CNT_W-1:0] cnt_reg;
  logic             stable_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else if (sync2_reg == stable_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
      stable_reg <= sync2_reg;
      cnt_reg    <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign level = stable_reg;
`else
  assign level = sync2_reg;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_d_reg <= 1'b0;
      pulse_reg   <= 1'b0;
    end else begin
      level_d_reg <= level;
      pulse_reg   <= level & ~level_d_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/msg_sequencer.sv
// -----------------------------------------------------------------------------
// msg_sequencer
//   Writable table of DEPTH messages presented one at a time on a valid/ready
//   handshake. Advances on a conditioned button press or an auto-play timer,
//   with wrap-around or stop-at-end. Button debounce is compiled in when the
//   macro MSG_SEQ_DEBOUNCE_EN is defined (default build: no debounce).
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   next_msg     in   raw push button (asynchronous)
//   restart      in   sync pulse: back to IDLE at entry 0
//   wrap         in   1 = wrap last->0, 0 = stop at last (DONE)
//   len          in   active entries; 0 or >DEPTH means DEPTH
//   auto_period  in   auto-advance interval in cycles, 0 = off
//   wr_en/wr_addr/wr_data in  table write port
//   msg          out  presented message (registered)
//   msg_valid    out  msg is valid
//   msg_ready    in   consumer accept
//   idx          out  index of presented / last-presented entry
//   last         out  idx == len-1 (registered)
//   done         out  stopped at end (registered)
// -----------------------------------------------------------------------------
module msg_sequencer
  import msg_seq_pkg::*;
#(
  parameter int MSG_W        = MSG_W_DEFAULT,
  parameter int DEPTH        = 8,
  parameter int IDX_W        = $clog2(DEPTH),
  parameter int DEBOUNCE_CYC = 16,
  parameter int AUTO_W       = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next_msg,
  input  logic              restart,
  input  logic              wrap,
  input  logic [IDX_W:0]    len,
  input  logic [AUTO_W-1:0] auto_period,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [MSG_W-1:0]  wr_data,
  output logic [MSG_W-1:0]  msg,
  output logic              msg_valid,
  input  logic              msg_ready,
  output logic [IDX_W-1:0]  idx,
  output logic              last,
  output logic              done
);

  localparam int                LEN_W   = IDX_W + 1;
  localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Message table
  // ---------------------------------------------------------------------------
  logic [MSG_W-1:0] table_reg [DEPTH];
  logic [DEPTH-1:0] wr_hit;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_dec
    assign wr_hit[gi] = wr_en && (wr_addr == IDX_W'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) table_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) table_reg[i] <= wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Advance sources
  // ---------------------------------------------------------------------------
  logic btn_pulse;

  btn_conditioner #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (next_msg),
    .pulse (btn_pulse)
  );

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              pending_reg, pending_next;
  logic [MSG_W-1:0]  msg_reg;
  logic              msg_valid_reg;
  logic              last_reg;
  logic              done_reg;
  logic              load_msg;
  logic [AUTO_W-1:0] timer_reg, timer_next;
  logic              timer_run;
  logic              auto_tick;
  logic              adv;

  // The timer only runs where an advance would act immediately.
  // Using >= keeps it from running away if auto_period shrinks mid-count.
  assign timer_run = ((state_reg == IDLE) || (state_reg == HOLD)) && (auto_period != '0);
  assign auto_tick = timer_run && (timer_reg >= (auto_period - AUTO_W'(1)));
  assign adv       = btn_pulse | auto_tick;

  always_comb begin
    timer_next = timer_reg + AUTO_W'(1);
    if (restart || adv || !timer_run) timer_next = '0;
  end

  // ---------------------------------------------------------------------------
  // Index arithmetic
  // ---------------------------------------------------------------------------
  logic [LEN_W-1:0] len_eff;
  logic             at_end;

  always_comb begin
    len_eff = len;
    if ((len == '0) || (len > DEPTH_L)) len_eff = DEPTH_L;
  end

  // ">=" rather than "==" so a len reduced below the current index still ends the run.
  assign at_end = (({1'b0, idx_reg} + LEN_W'(1)) >= len_eff);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    pending_next = pending_reg;
    load_msg     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (adv) begin
          state_next = PRESENT;
          idx_next   = '0;
          load_msg   = 1'b1;
        end
      end

      PRESENT: begin
        // One-deep: a second advance while pending is simply absorbed.
        if (adv) pending_next = 1'b1;
        // Acceptance always passes through HOLD, which gives the bubble cycle
        // before a pending advance is serviced.
        if (msg_ready) state_next = HOLD;
      end

      HOLD: begin
        if (adv || pending_reg) begin
          pending_next = 1'b0;
          if (at_end && !wrap) begin
            state_next = DONE;
          end else begin
            state_next = PRESENT;
            idx_next   = at_end ? '0 : idx_reg + IDX_W'(1);
            load_msg   = 1'b1;
          end
        end
      end

      DONE: begin
        pending_next = 1'b0;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (restart) begin
      state_next   = IDLE;
      idx_next     = '0;
      pending_next = 1'b0;
      load_msg     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      pending_reg   <= 1'b0;
      timer_reg     <= '0;
      msg_reg       <= '0;
      msg_valid_reg <= 1'b0;
      last_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      pending_reg   <= pending_next;
      timer_reg     <= timer_next;
      // Table read happens before any same-edge write lands, so a write to
      // the entry being presented only shows up at its next presentation.
      if (load_msg) msg_reg <= table_reg[idx_next];
      msg_valid_reg <= (state_next == PRESENT);
      done_reg      <= (state_next == DONE);
      last_reg      <= (state_next != IDLE) &&
                       (({1'b0, idx_next} + LEN_W'(1)) == len_eff);
    end
  end

  assign msg       = msg_reg;
  assign msg_valid = msg_valid_reg;
  assign idx       = idx_reg;
  assign last      = last_reg;
  assign done      = done_reg;

endmodule
